// File: rtl/alu_issue_ctrl.sv
// Issue control for a DSP-style ALU: registered operands/controls, writeback after LAT_ALU/LAT_MUL cycles.
// Backpressure: in_ready drops on writeback-slot or destination-tag collision with an in-flight op.
module alu_issue_ctrl #(
    parameter int LAT_MUL = 5,
    parameter int LAT_ALU = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [3:0]  in_tag,
    input  logic [29:0] in_a,
    input  logic [17:0] in_b,
    input  logic [47:0] in_c,
    output logic [29:0] a_o,
    output logic [17:0] b_o,
    output logic [47:0] c_o,
    output logic [3:0]  alumode_o,
    output logic [6:0]  opmode_o,
    output logic [4:0]  inmode_o,
    output logic        usemult_o,
    output logic        cea2_o,
    output logic        ceb2_o,
    input  logic [47:0] p_i,
    output logic        wb_valid,
    output logic [3:0]  wb_tag,
    output logic [47:0] wb_data,
    output logic [3:0]  inflight_o
);

    logic [LAT_MUL:1] slot_vld;
    logic [3:0]       slot_tag [1:LAT_MUL];

    logic       is_nop;
    logic       is_mul;
    logic       port_busy;
    logic       tag_busy;
    logic       issue;
    logic       issue_op;
    int         lat;
    logic [6:0] dec_opmode;
    logic [3:0] dec_alumode;
    logic       dec_usemult;

    // An op issued now lands in slot LAT after the shift, i.e. it collides with today's slot LAT+1.
    always_comb begin
        is_nop    = (in_op == 3'd0);
        is_mul    = (in_op == 3'd3) || (in_op == 3'd4);
        lat       = is_mul ? LAT_MUL : LAT_ALU;
        port_busy = 1'b0;
        tag_busy  = 1'b0;
        for (int i = 1; i <= LAT_MUL; i++) begin
            if (i == lat + 1 && slot_vld[i]) port_busy = 1'b1;
            if (slot_vld[i] && slot_tag[i] == in_tag) tag_busy = 1'b1;
        end
        // NOP occupies neither a writeback slot nor a tag, so it is never held off.
        in_ready = is_nop || !(port_busy || tag_busy);
    end

    assign issue    = in_valid && in_ready;
    assign issue_op = issue && !is_nop;

    always_comb begin
        dec_opmode  = 7'b0000000;
        dec_alumode = 4'b0000;
        dec_usemult = 1'b0;
        case (in_op)
            3'd1: dec_opmode = 7'b0110011;
            3'd2: begin dec_opmode = 7'b0110011; dec_alumode = 4'b0011; end
            3'd3: begin dec_opmode = 7'b0000101; dec_usemult = 1'b1; end
            3'd4: begin dec_opmode = 7'b0110101; dec_usemult = 1'b1; end
            3'd5: begin dec_opmode = 7'b0110011; dec_alumode = 4'b1100; end
            3'd6: begin dec_opmode = 7'b0111011; dec_alumode = 4'b1100; end
            3'd7: begin dec_opmode = 7'b0110011; dec_alumode = 4'b0100; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
            for (int i = 1; i <= LAT_MUL; i++) slot_tag[i] <= 4'd0;
        end else begin
            for (int i = 1; i < LAT_MUL; i++) begin
                slot_vld[i] <= slot_vld[i+1];
                slot_tag[i] <= slot_tag[i+1];
            end
            slot_vld[LAT_MUL] <= 1'b0;
            slot_tag[LAT_MUL] <= 4'd0;
            if (issue_op) begin
                for (int i = 1; i <= LAT_MUL; i++) begin
                    if (i == lat) begin
                        slot_vld[i] <= 1'b1;
                        slot_tag[i] <= in_tag;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_o       <= '0;
            b_o       <= '0;
            c_o       <= '0;
            opmode_o  <= '0;
            alumode_o <= '0;
            inmode_o  <= '0;
            usemult_o <= 1'b0;
            cea2_o    <= 1'b0;
            ceb2_o    <= 1'b0;
        end else begin
            opmode_o  <= issue_op ? dec_opmode  : 7'b0000000;
            alumode_o <= issue_op ? dec_alumode : 4'b0000;
            usemult_o <= issue_op ? dec_usemult : 1'b0;
            inmode_o  <= 5'b00000;
            cea2_o    <= issue_op;
            ceb2_o    <= issue_op;
            if (issue) begin
                a_o <= in_a;
                b_o <= in_b;
                c_o <= in_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_tag     <= 4'd0;
            wb_data    <= 48'd0;
            inflight_o <= 4'd0;
        end else begin
            wb_valid   <= slot_vld[1];
            inflight_o <= inflight_o + 4'(issue_op) - 4'(slot_vld[1]);
            if (slot_vld[1]) begin
                wb_tag  <= slot_tag[1];
                wb_data <= p_i;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: scoreboard of expected writebacks (tag, data, edge) with a separate monitor.
module tb_alu_issue_ctrl;
    localparam int LAT_MUL = 5;
    localparam int LAT_ALU = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [3:0]  in_tag;
    logic [29:0] in_a;
    logic [17:0] in_b;
    logic [47:0] in_c;
    logic [29:0] a_o;
    logic [17:0] b_o;
    logic [47:0] c_o;
    logic [3:0]  alumode_o;
    logic [6:0]  opmode_o;
    logic [4:0]  inmode_o;
    logic        usemult_o;
    logic        cea2_o;
    logic        ceb2_o;
    logic [47:0] p_i;
    logic        wb_valid;
    logic [3:0]  wb_tag;
    logic [47:0] wb_data;
    logic [3:0]  inflight_o;

    alu_issue_ctrl #(.LAT_MUL(LAT_MUL), .LAT_ALU(LAT_ALU)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_tag(in_tag), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .alumode_o(alumode_o), .opmode_o(opmode_o),
        .inmode_o(inmode_o), .usemult_o(usemult_o), .cea2_o(cea2_o), .ceb2_o(ceb2_o),
        .p_i(p_i), .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .inflight_o(inflight_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [47:0] data;
        int          done;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [47:0] sched [int];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cnt   = 0;
    int          peak  = 0;
    logic        prev_ce = 1'b0;
    logic [2:0]  prev_op = 3'd0;

    always @(posedge clk) cnt <= cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural result of each opcode, straight from its definition.
    function automatic logic [47:0] ref_result(input logic [2:0] op, input logic [29:0] a,
                                               input logic [17:0] b, input logic [47:0] c);
        logic [47:0] ab;
        logic [47:0] m;
        ab = {a, b};
        m  = 48'(a) * 48'(b);
        case (op)
            3'd1: return c + ab;
            3'd2: return c - ab;
            3'd3: return m;
            3'd4: return c + m;
            3'd5: return ab & c;
            3'd6: return ab | c;
            3'd7: return ab ^ c;
            default: return 48'd0;
        endcase
    endfunction

    // {opmode, alumode, usemult} expected for each opcode.
    function automatic logic [11:0] exp_ctrl(input logic [2:0] op);
        case (op)
            3'd1: return {7'b0110011, 4'b0000, 1'b0};
            3'd2: return {7'b0110011, 4'b0011, 1'b0};
            3'd3: return {7'b0000101, 4'b0000, 1'b1};
            3'd4: return {7'b0110101, 4'b0000, 1'b1};
            3'd5: return {7'b0110011, 4'b1100, 1'b0};
            3'd6: return {7'b0111011, 4'b1100, 1'b0};
            3'd7: return {7'b0110011, 4'b0100, 1'b0};
            default: return 12'd0;
        endcase
    endfunction

    // ALU core stand-in: interprets the control word it is handed.
    function automatic logic [47:0] core(input logic [11:0] ctl, input logic [29:0] a,
                                         input logic [17:0] b, input logic [47:0] c);
        logic [47:0] ab;
        ab = {a, b};
        case (ctl)
            {7'b0110011, 4'b0000, 1'b0}: return c + ab;
            {7'b0110011, 4'b0011, 1'b0}: return c - ab;
            {7'b0000101, 4'b0000, 1'b1}: return 48'(a) * 48'(b);
            {7'b0110101, 4'b0000, 1'b1}: return c + 48'(a) * 48'(b);
            {7'b0110011, 4'b1100, 1'b0}: return ab & c;
            {7'b0111011, 4'b1100, 1'b0}: return ab | c;
            {7'b0110011, 4'b0100, 1'b0}: return ab ^ c;
            default: return 48'hBAD0_BAD0_BAD0;
        endcase
    endfunction

    // Core pipeline: result for an op launched at edge E is presented on p_i during the cycle before edge E+LAT.
    always @(negedge clk) begin
        if (!rst && cea2_o === 1'b1)
            sched[cnt + (usemult_o ? LAT_MUL : LAT_ALU) - 1] = core({opmode_o, alumode_o, usemult_o}, a_o, b_o, c_o);
        if (sched.exists(cnt)) begin
            p_i <= sched[cnt];
            sched.delete(cnt);
        end else begin
            p_i <= {16'($urandom), $urandom};
        end
    end

    // Monitor: every writeback must match the oldest expected completion, on its exact edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("wb_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("wb_tag", 64'(wb_tag), 64'(mon_e.tag));
                    chk("wb_data", 64'(wb_data), 64'(mon_e.data));
                    chk("wb_edge", 64'(cnt), 64'(mon_e.done));
                end
            end else if (sbq.size() > 0 && sbq[0].done <= cnt) begin
                mon_e = sbq.pop_front();
                chk("wb_missing", 64'd0, 64'(mon_e.tag) + 64'd1);
            end
        end
    end

    // One cycle of stimulus, entered at a falling edge; checks the combinational/registered view and models issue.
    task automatic do_cycle(input logic v, input logic [2:0] op, input logic [3:0] tag, input logic [29:0] a,
                            input logic [17:0] b, input logic [47:0] c, output logic acc);
        int   lat;
        int   n;
        int   infl;
        int   k;
        logic busy;
        logic rdy;
        exp_t e;
        in_valid = v; in_op = op; in_tag = tag; in_a = a; in_b = b; in_c = c;
        #1;
        n    = cnt;
        lat  = (op == 3'd3 || op == 3'd4) ? LAT_MUL : LAT_ALU;
        busy = 1'b0;
        infl = 0;
        foreach (sbq[i]) begin
            if (sbq[i].done >= n + 1) begin
                infl++;
                if (sbq[i].done == n + 1 + lat || sbq[i].tag == tag) busy = 1'b1;
            end
        end
        rdy = (op == 3'd0) || !busy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("inflight_o", 64'(inflight_o), 64'(infl));
        chk("cea2_o", 64'(cea2_o), 64'(prev_ce));
        chk("ceb2_o", 64'(ceb2_o), 64'(prev_ce));
        chk("alu_ctrl", 64'({opmode_o, alumode_o, usemult_o, inmode_o}),
            prev_ce ? 64'({exp_ctrl(prev_op), 5'b00000}) : 64'd0);
        if (int'(inflight_o) > peak) peak = int'(inflight_o);
        acc = v && in_ready;
        if (acc && op != 3'd0) begin
            e.tag  = tag;
            e.data = ref_result(op, a, b, c);
            e.done = n + 1 + lat;
            k = sbq.size();
            while (k > 0 && sbq[k-1].done > e.done) k--;
            sbq.insert(k, e);
        end
        prev_ce = acc && (op != 3'd0);
        prev_op = op;
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] tag, input logic [29:0] a,
                        input logic [17:0] b, input logic [47:0] c, output int stalls);
        logic acc;
        acc    = 1'b0;
        stalls = 0;
        for (int t = 0; t < 30 && !acc; t++) begin
            do_cycle(1'b1, op, tag, a, b, c, acc);
            if (!acc) stalls++;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) do_cycle(1'b0, 3'd1, 4'(i), 30'd0, 18'd0, 48'd0, acc);
    endtask

    initial begin
        int   st;
        int   tot;
        logic acc;
        in_valid = 1'b0; in_op = 3'd1; in_tag = 4'd0; in_a = '0; in_b = '0; in_c = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_wb_tag", 64'(wb_tag), 64'd0);
        chk("rst_wb_data", 64'(wb_data), 64'd0);
        chk("rst_inflight", 64'(inflight_o), 64'd0);
        chk("rst_operands", 64'({a_o, b_o}) | 64'(c_o), 64'd0);
        chk("rst_ctrl", 64'({opmode_o, alumode_o, inmode_o, usemult_o, cea2_o, ceb2_o}), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First edge after release accepts; ADD 10 + {0,5} = 15 on tag 3.
        send(3'd1, 4'd3, 30'd0, 18'd5, 48'd10, st);
        chk("first_issue_stall", 64'(st), 64'd0);
        idle(8);

        // MUL then ADD: the ADD targets the MUL's writeback slot once.
        do_cycle(1'b1, 3'd3, 4'd1, 30'd3, 18'd7, 48'd0, acc);
        chk("mul_accept", 64'(acc), 64'd1);
        send(3'd1, 4'd2, 30'd1, 18'd2, 48'd100, st);
        chk("mul_add_stall", 64'(st), 64'd1);
        idle(8);

        // Same tag back-to-back: second waits for the first writeback.
        peak = 0;
        send(3'd1, 4'd5, 30'd0, 18'd1, 48'd1, st);
        send(3'd1, 4'd5, 30'd0, 18'd2, 48'd2, st);
        chk("same_tag_stall", 64'(st), 64'd4);
        idle(8);
        chk("same_tag_peak", 64'(peak), 64'd1);

        // Eight ADDs streaming with distinct tags.
        peak = 0;
        tot  = 0;
        for (int i = 0; i < 8; i++) begin
            send(3'd1, 4'(i), 30'(i), 18'(i * 3), 48'(i * 1000), st);
            tot += st;
        end
        idle(8);
        chk("stream_stalls", 64'(tot), 64'd0);
        chk("stream_peak", 64'(peak), 64'd4);

        // Reset with three ops in flight: nothing may write back afterwards.
        for (int i = 0; i < 3; i++) send(3'd1, 4'(8 + i), 30'd1, 18'd1, 48'd1, st);
        rst = 1'b1;
        #1;
        chk("async_rst_inflight", 64'(inflight_o), 64'd0);
        chk("async_rst_operands", 64'(a_o), 64'd0);
        sbq.delete();
        prev_ce = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(10);

        // NOP then SUB 20 - 8 = 12.
        send(3'd0, 4'd9, 30'd5, 18'd5, 48'd5, st);
        idle(2);
        send(3'd2, 4'd4, 30'd0, 18'd8, 48'd20, st);
        idle(8);

        // Randomised mix; tags confined to 0..7 so tag hazards are frequent.
        for (int i = 0; i < 400; i++) begin
            do_cycle(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                     30'($urandom), 18'($urandom), {16'($urandom), $urandom}, acc);
        end
        idle(12);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter LAT_MUL, default 5, cycles from issue handshake to wb_valid for multiplier ops (legal 2..8).
REQ-002 Parameter LAT_ALU, default 4, cycles from issue handshake to wb_valid for non-multiplier ops (legal 2..8, LAT_ALU < LAT_MUL).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  instruction present.
REQ-006 in_ready  output  1  instruction accepted when in_valid and in_ready are high on the same edge ("issue").
REQ-007 in_op  input  3  opcode: 0 NOP, 1 ADD, 2 SUB, 3 MUL, 4 MACC, 5 AND, 6 OR, 7 XOR.
REQ-008 in_tag  input  4  destination tag returned with the result.
REQ-009 in_a / in_b / in_c  input  30 / 18 / 48  operands.
REQ-010 a_o / b_o / c_o  output  30 / 18 / 48  operands to the ALU core.
REQ-011 alumode_o 4, opmode_o 7, inmode_o 5, usemult_o 1, cea2_o 1, ceb2_o 1  outputs  ALU core controls.
REQ-012 p_i  input  48  ALU core result.
REQ-013 wb_valid / wb_tag / wb_data  output  1 / 4 / 48  writeback strobe, tag, result.
REQ-014 inflight_o  output  4  number of issued, not yet written-back ops.

Function
REQ-015 All ALU-side outputs registered; loaded on issue, otherwise hold operands and force controls to idle (opmode 0000000, alumode 0000, inmode 00000, usemult 0, cea2/ceb2 0).
REQ-016 On issue of a non-NOP op, cea2_o = ceb2_o = 1 for exactly one cycle; inmode_o = 00000.
REQ-017 Encoding (opmode/alumode/usemult): ADD 0110011/0000/0 (C+A:B); SUB 0110011/0011/0 (C-A:B); MUL 0000101/0000/1; MACC 0110101/0000/1 (C+A*B); AND 0110011/1100/0; OR 0111011/1100/0; XOR 0110011/0100/0.
REQ-018 NOP issues: in_ready honoured, ALU controls stay idle, no writeback, inflight_o unchanged.
REQ-019 Completion tracking: shift register of depth LAT_MUL, each slot {valid, tag}; issued op inserted at slot LAT (LAT_MUL or LAT_ALU per op), shifted one slot toward slot 1 each cycle.
REQ-020 When slot 1 valid: wb_valid = 1 for one cycle, wb_tag = slot tag, wb_data = p_i sampled that cycle (registered, so visible one edge later; LAT counts to the wb_valid edge).
REQ-021 Writeback-port hazard: in_ready = 0 when the target slot of the presented op (after this cycle's shift) is already valid; ops never complete out of slot order and never collide.
REQ-022 Tag hazard: in_ready = 0 when in_tag matches any valid slot tag (no two in-flight ops share a tag).
REQ-023 in_ready is combinational from in_op, in_tag and slot state; it does not depend on in_valid.
REQ-024 inflight_o = count of valid slots; increments on non-NOP issue, decrements on wb; simultaneous issue and wb leaves it unchanged.
REQ-025 Back-to-back: same-latency ops with distinct tags issue every cycle with in_ready = 1 and write back on consecutive cycles in issue order.
REQ-026 ALU op issued one cycle after MUL: accepted only if its slot is free; LAT_MUL - LAT_ALU = 1 with defaults means ALU op issued the cycle after MUL stalls exactly one cycle.

Reset
REQ-027 rst asserted: all slots invalid, wb_valid 0, wb_tag 0, wb_data 0, inflight_o 0, ALU controls idle, a_o/b_o/c_o 0, immediately (asynchronous).
REQ-028 in_ready is 1 while out of reset with no valid slots; in-flight ops during reset are discarded, no writeback after release.
REQ-029 Deassertion: first issue is accepted on the first rising edge with rst low.

Verification
REQ-030 ADD tag 3, a=0, b=5, c=10, ALU model returns C+A:B -> 4 cycles later wb_valid=1, wb_tag=3, wb_data=15, single pulse.
REQ-031 MUL tag 1 (a=3,b=7) then ADD tag 2 next cycle -> ADD sees in_ready=0 for 1 cycle; wb tag1=21 then tag2 on next cycle.
REQ-032 Two ADDs both tag 5 back-to-back -> second stalls until first writes back; inflight_o never exceeds 1.
REQ-033 Eight ADDs tags 0..7 consecutive cycles -> no stall, eight consecutive wb pulses, tags 0..7, inflight_o peaks at 4.
REQ-034 rst pulsed with 3 ops in flight -> no wb_valid after release, inflight_o=0, in_ready=1.
REQ-035 NOP and SUB (c=20, b=8) -> NOP no wb/no cea2; SUB alumode_o=0011, wb_data=12.
